predictor_phase_sequencer: RTL and testbench
============================================

# predictor_phase_sequencer

Parametrised trigger sequencer for the predictor datapath. On request it steps through NUM_PHASES mutually exclusive, registered one-hot trigger strobes (phase 0 = latch, 1 = update, 2 = predict in the default build), each held PHASE_CYCLES clocks. Each sequence ends with GAP_CYCLES all-zero cycles. It runs single-shot or continuously, and supports abort, completion pulses and a sequence counter. It sits between the predictor clock domain root and the latch/update/predict stages.

## Interface
Parameters:
- NUM_PHASES, 3: number of trigger phases, ≥ 2
- PHASE_CYCLES, 1: clocks each trigger is held, ≥ 1
- GAP_CYCLES, 1: all-zero clocks after the last phase, ≥ 1
- COUNT_W, 16: width of seq_count

Ports:
- clock  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request one sequence; sampled only in IDLE
- continuous  in  1  level; when high at sequence end, restart with no idle cycle
- abort  in  1  terminate current sequence; highest priority after reset
- phase_trigger  out  NUM_PHASES  one-hot strobe of the current phase, zero otherwise
- phase_index  out  $clog2(NUM_PHASES)  index of the current phase, 0 when not in RUN
- busy  out  1  high in RUN and GAP
- seq_done  out  1  one-cycle pulse after a sequence completes normally
- seq_count  out  COUNT_W  completed sequences, wraps modulo 2^COUNT_W

## Operation
- States: IDLE, RUN, GAP. A dwell counter and a phase counter run in RUN; the dwell counter runs in GAP.
- IDLE: with start=1 and abort=0, go to RUN with phase 0 and dwell 0. Otherwise stay in IDLE.
- RUN: phase_trigger[phase]=1. When dwell reaches PHASE_CYCLES-1, advance phase and reset dwell. After the last phase, go to GAP.
- GAP: phase_trigger=0. When dwell reaches GAP_CYCLES-1, the sequence completes:
  - seq_count increments;
  - next state is RUN phase 0 if continuous=1, otherwise IDLE.
- start is ignored while busy.
- abort=1 in any state forces IDLE next cycle with all triggers low. No seq_done pulse and no count change. abort beats start in the same cycle.
- reset forces IDLE, phase_trigger=0, phase_index=0, busy=0, seq_done=0, seq_count=0. Reset mid-sequence behaves like abort and also clears the count.
- All outputs are registered. phase_trigger is never more than one-hot.

## Timing
- start sampled at edge t: phase_trigger[0] high during cycles t+1 … t+PHASE_CYCLES.
- Sequence length is NUM_PHASES·PHASE_CYCLES + GAP_CYCLES cycles.
- seq_done is high, and seq_count shows the new value, in the first cycle after the last GAP cycle. In continuous mode this coincides with the next phase-0 cycle.
- Default configuration gives a 4-cycle period: latch, update, predict, idle.
- abort sampled at edge t: all outputs except seq_count are zero from cycle t+1.

## Configuration
- PREDICTOR_SEQ_STALL_EN defined:
  - adds input stall (1 bit);
  - stall=1 in RUN or GAP freezes state, counters and phase_trigger; the active trigger stays asserted;
  - seq_done stays single-cycle;
  - stall is ignored in IDLE;
  - abort and reset override stall.
- Not defined: there is no stall port, and behaviour is identical to stall=0.

## Structure
- Package predictor_seq_pkg: state enum (IDLE, RUN, GAP) and the index-width helper function.
- Sub-module predictor_seq_timer: dwell counter with load, enable (stall), and an expire flag at a programmable terminal count. It is instantiated once and shared by RUN and GAP.

## Test plan
- Defaults, start pulse at cycle 0, continuous=0 → phase_trigger 001/010/100 at cycles 1/2/3; 000 and busy=1 at cycle 4; seq_done=1, busy=0, seq_count=1 at cycle 5.
- Defaults, continuous=1, start at 0 → phase 0 at cycles 1, 5, 9; seq_done at cycles 5, 9, 13; seq_count=3 at cycle 13.
- PHASE_CYCLES=3, GAP_CYCLES=2 → each trigger high 3 cycles, 2 zero cycles, seq_done 12 cycles after start.
- abort with start during phase 1 → cycle after abort: all zero, busy=0, no seq_done, count unchanged, no restart. Reset mid-RUN → seq_count=0.
- COUNT_W=2, five single-shot sequences → seq_count 1, 2, 3, 0, 1.
- PREDICTOR_SEQ_STALL_EN, stall high 2 cycles during phase 1 → phase_trigger=010 for 3 cycles, seq_done 2 cycles later; stall during the GAP's last cycle still gives a one-cycle seq_done.

Source files
------------

// File: rtl/predictor_seq_pkg.sv
// Shared definitions for the predictor phase sequencer: FSM state encodings
// and the index-width helper used to size phase and dwell counters.
package predictor_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Bits needed to index n items; never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/predictor_seq_timer.sv
// Dwell counter shared by the RUN and GAP states: synchronous clear on load,
// advance on enable, expire flag when the count equals the terminal value.
module predictor_seq_timer #(
  parameter int W = 4
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_terminal,
  output logic [W-1:0] o_count,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  // Dwell count: load has priority over enable so a state change always restarts at zero.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count  = r_count;
  assign o_expire = (r_count == i_terminal);

endmodule

// File: rtl/predictor_phase_sequencer.sv
// One-hot latch/update/predict trigger sequencer with gap, continuous mode,
// abort and completion count. Optional stall input under PREDICTOR_SEQ_STALL_EN.
module predictor_phase_sequencer
  import predictor_seq_pkg::*;
#(
  parameter int NUM_PHASES   = 3,
  parameter int PHASE_CYCLES = 1,
  parameter int GAP_CYCLES   = 1,
  parameter int COUNT_W      = 16
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic                                i_start,
  input  logic                                i_continuous,
  input  logic                                i_abort,
`ifdef PREDICTOR_SEQ_STALL_EN
  input  logic                                i_stall,
`endif
  output logic [NUM_PHASES-1:0]               o_phase_trigger,
  output logic [idx_width(NUM_PHASES)-1:0]    o_phase_index,
  output logic                                o_busy,
  output logic                                o_seq_done,
  output logic [COUNT_W-1:0]                  o_seq_count
);

  localparam int IW   = idx_width(NUM_PHASES);
  localparam int MAXC = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int DW   = idx_width(MAXC);

  localparam logic [IW-1:0] LAST_PHASE = IW'(NUM_PHASES - 1);
  localparam logic [DW-1:0] PH_TC      = DW'(PHASE_CYCLES - 1);
  localparam logic [DW-1:0] GAP_TC     = DW'(GAP_CYCLES - 1);

  logic [1:0]            r_state;
  logic [IW-1:0]         r_phase;
  logic [NUM_PHASES-1:0] r_trigger;
  logic [IW-1:0]         r_index;
  logic                  r_busy;
  logic                  r_done;
  logic [COUNT_W-1:0]    r_count;

  logic [1:0]            w_state_nxt;
  logic [IW-1:0]         w_phase_nxt;
  logic [NUM_PHASES-1:0] w_trig_nxt;
  logic                  w_load;
  logic                  w_en;
  logic                  w_done;
  logic                  w_stall;
  logic                  w_expire;
  logic [DW-1:0]         w_terminal;
  logic [DW-1:0]         w_dwell;

`ifdef PREDICTOR_SEQ_STALL_EN
  assign w_stall = i_stall;
`else
  assign w_stall = 1'b0;
`endif

  predictor_seq_timer #(.W(DW)) u_timer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_en       (w_en),
    .i_terminal (w_terminal),
    .o_count    (w_dwell),
    .o_expire   (w_expire)
  );

  // Next-state, phase advance and timer control; abort outranks everything but reset.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_load      = 1'b0;
    w_en        = 1'b0;
    w_done      = 1'b0;
    if (r_state == ST_GAP) begin
      w_terminal = GAP_TC;
    end else begin
      w_terminal = PH_TC;
    end

    if (i_abort) begin
      w_state_nxt = ST_IDLE;
      w_phase_nxt = '0;
      w_load      = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_load = 1'b1;
          if (i_start) begin
            w_state_nxt = ST_RUN;
            w_phase_nxt = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_stall) begin
            w_en = 1'b0;
          end else if (!w_expire) begin
            w_en = 1'b1;
          end else if (r_phase == LAST_PHASE) begin
            w_state_nxt = ST_GAP;
            w_phase_nxt = '0;
            w_load      = 1'b1;
          end else begin
            w_phase_nxt = r_phase + IW'(1);
            w_load      = 1'b1;
          end
        end
        ST_GAP: begin
          if (w_stall) begin
            w_en = 1'b0;
          end else if (!w_expire) begin
            w_en = 1'b1;
          end else begin
            // Sequence complete: back-to-back restart skips IDLE entirely.
            w_done      = 1'b1;
            w_load      = 1'b1;
            w_phase_nxt = '0;
            if (i_continuous) begin
              w_state_nxt = ST_RUN;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_phase_nxt = '0;
          w_load      = 1'b1;
        end
      endcase
    end
  end

  // Trigger decode from next state so the strobe itself comes straight from a flop.
  always_comb begin
    w_trig_nxt = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      w_trig_nxt[i] = (w_state_nxt == ST_RUN) && (w_phase_nxt == IW'(i));
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_phase   <= '0;
      r_trigger <= '0;
      r_index   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_trigger <= w_trig_nxt;
      r_index   <= (w_state_nxt == ST_RUN) ? w_phase_nxt : '0;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= w_done;
      r_count   <= w_done ? (r_count + COUNT_W'(1)) : r_count;
    end
  end

  assign o_phase_trigger = r_trigger;
  assign o_phase_index   = r_index;
  assign o_busy          = r_busy;
  assign o_seq_done      = r_done;
  assign o_seq_count     = r_count;

endmodule

// File: tb/tb_predictor_phase_sequencer.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs, a negedge
// monitor pops and compares. Stall scenarios run when PREDICTOR_SEQ_STALL_EN is defined.
module tb_predictor_phase_sequencer;

  logic clk = 1'b0;
  logic reset, start_a, cont_a, abort_a, stall_a, start_b;
  logic [2:0]  trig_a, trig_b;
  logic [1:0]  idx_a, idx_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int          cyc;
    int          id;
    logic [2:0]  trig;
    logic [1:0]  idx;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  predictor_phase_sequencer u_a (
    .i_clock(clk), .i_reset(reset), .i_start(start_a), .i_continuous(cont_a),
    .i_abort(abort_a),
`ifdef PREDICTOR_SEQ_STALL_EN
    .i_stall(stall_a),
`endif
    .o_phase_trigger(trig_a), .o_phase_index(idx_a), .o_busy(busy_a),
    .o_seq_done(done_a), .o_seq_count(cnt_a)
  );

  predictor_phase_sequencer #(.PHASE_CYCLES(3), .GAP_CYCLES(2), .COUNT_W(2)) u_b (
    .i_clock(clk), .i_reset(reset), .i_start(start_b), .i_continuous(1'b0),
    .i_abort(1'b0),
`ifdef PREDICTOR_SEQ_STALL_EN
    .i_stall(1'b0),
`endif
    .o_phase_trigger(trig_b), .o_phase_index(idx_b), .o_busy(busy_b),
    .o_seq_done(done_b), .o_seq_count(cnt_b)
  );

  task automatic push(input int id, input int c, input logic [2:0] trig, input logic [1:0] idx,
                      input logic busy, input logic done, input int cnt);
    exp_t e;
    e.cyc = c; e.id = id; e.trig = trig; e.idx = idx; e.busy = busy; e.done = done;
    e.cnt = 16'(cnt);
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every expectation due this cycle, flag stale ones.
  always @(negedge clk) begin
    logic [22:0] act, exp_v;
    n_chk++;
    if (!$onehot0(trig_a) || !$onehot0(trig_b)) begin
      n_err++;
      $display("FAIL onehot cyc=%0d got a=%b b=%b want at most one bit", cyc, trig_a, trig_b);
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        if (sb[i].id == 0) act = {trig_a, idx_a, busy_a, done_a, cnt_a};
        else               act = {trig_b, idx_b, busy_b, done_b, 14'd0, cnt_b};
        exp_v = {sb[i].trig, sb[i].idx, sb[i].busy, sb[i].done, sb[i].cnt};
        n_chk++;
        if (act !== exp_v) begin
          n_err++;
          $display("FAIL outputs dut=%0d cyc=%0d got trig=%b idx=%0d busy=%b done=%b cnt=%0d want trig=%b idx=%0d busy=%b done=%b cnt=%0d",
                   sb[i].id, cyc, act[22:20], act[19:18], act[17], act[16], act[15:0],
                   sb[i].trig, sb[i].idx, sb[i].busy, sb[i].done, sb[i].cnt);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_chk++;
        n_err++;
        $display("FAIL stale dut=%0d cyc=%0d got unchecked want checked", sb[i].id, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  int b;
  int cnt_after[5] = '{1, 2, 3, 0, 1};

  initial begin
    reset = 1'b1; start_a = 1'b0; cont_a = 1'b0; abort_a = 1'b0; stall_a = 1'b0; start_b = 1'b0;
    push(0, 1, 3'b000, 2'd0, 1'b0, 1'b0, 0);
    push(1, 1, 3'b000, 2'd0, 1'b0, 1'b0, 0);
    tick(1);
    reset = 1'b0;
    tick(1);

    // Continuous: phase 0 at +1,+5,+9; done at +5,+9,+13
    b = cyc;
    start_a = 1'b1; cont_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(0, b + 1 + 4*k, 3'b001, 2'd0, 1'b1, (k > 0), k);
      push(0, b + 2 + 4*k, 3'b010, 2'd1, 1'b1, 1'b0, k);
      push(0, b + 3 + 4*k, 3'b100, 2'd2, 1'b1, 1'b0, k);
      push(0, b + 4 + 4*k, 3'b000, 2'd0, 1'b1, 1'b0, k);
    end
    push(0, b + 13, 3'b000, 2'd0, 1'b0, 1'b1, 3);
    push(0, b + 14, 3'b000, 2'd0, 1'b0, 1'b0, 3);
    tick(1);
    start_a = 1'b0;
    tick(9);
    cont_a = 1'b0;
    tick(5);

    // Single shot with default timing
    b = cyc;
    start_a = 1'b1;
    push(0, b + 1, 3'b001, 2'd0, 1'b1, 1'b0, 3);
    push(0, b + 2, 3'b010, 2'd1, 1'b1, 1'b0, 3);
    push(0, b + 3, 3'b100, 2'd2, 1'b1, 1'b0, 3);
    push(0, b + 4, 3'b000, 2'd0, 1'b1, 1'b0, 3);
    push(0, b + 5, 3'b000, 2'd0, 1'b0, 1'b1, 4);
    push(0, b + 6, 3'b000, 2'd0, 1'b0, 1'b0, 4);
    tick(1);
    start_a = 1'b0;
    tick(6);

    // Abort together with start during phase 1
    b = cyc;
    start_a = 1'b1;
    push(0, b + 1, 3'b001, 2'd0, 1'b1, 1'b0, 4);
    push(0, b + 2, 3'b010, 2'd1, 1'b1, 1'b0, 4);
    push(0, b + 3, 3'b000, 2'd0, 1'b0, 1'b0, 4);
    push(0, b + 4, 3'b000, 2'd0, 1'b0, 1'b0, 4);
    push(0, b + 5, 3'b000, 2'd0, 1'b0, 1'b0, 4);
    push(0, b + 6, 3'b000, 2'd0, 1'b0, 1'b0, 4);
    tick(1);
    start_a = 1'b0;
    tick(1);
    start_a = 1'b1; abort_a = 1'b1;
    tick(1);
    start_a = 1'b0; abort_a = 1'b0;
    tick(1);
    start_a = 1'b1; abort_a = 1'b1;    // abort beats start in IDLE too
    tick(1);
    start_a = 1'b0; abort_a = 1'b0;
    tick(2);

    // Reset mid-RUN clears the count
    b = cyc;
    start_a = 1'b1;
    push(0, b + 1, 3'b001, 2'd0, 1'b1, 1'b0, 4);
    push(0, b + 2, 3'b010, 2'd1, 1'b1, 1'b0, 4);
    push(0, b + 3, 3'b000, 2'd0, 1'b0, 1'b0, 0);
    push(0, b + 4, 3'b000, 2'd0, 1'b0, 1'b0, 0);
    tick(1);
    start_a = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);

    // PHASE_CYCLES=3, GAP_CYCLES=2, COUNT_W=2: five shots wrap the count
    for (int k = 0; k < 5; k++) begin
      b = cyc;
      start_b = 1'b1;
      for (int p = 0; p < 3; p++) begin
        for (int d = 0; d < 3; d++) begin
          push(1, b + 1 + 3*p + d, 3'(1 << p), 2'(p), 1'b1, 1'b0, (k == 0) ? 0 : cnt_after[k-1]);
        end
      end
      push(1, b + 10, 3'b000, 2'd0, 1'b1, 1'b0, (k == 0) ? 0 : cnt_after[k-1]);
      push(1, b + 11, 3'b000, 2'd0, 1'b1, 1'b0, (k == 0) ? 0 : cnt_after[k-1]);
      push(1, b + 12, 3'b000, 2'd0, 1'b0, 1'b1, cnt_after[k]);
      push(1, b + 13, 3'b000, 2'd0, 1'b0, 1'b0, cnt_after[k]);
      tick(1);
      start_b = 1'b0;
      tick(12);
    end

`ifdef PREDICTOR_SEQ_STALL_EN
    // Stall two cycles during phase 1
    b = cyc;
    start_a = 1'b1;
    push(0, b + 1, 3'b001, 2'd0, 1'b1, 1'b0, 0);
    push(0, b + 2, 3'b010, 2'd1, 1'b1, 1'b0, 0);
    push(0, b + 3, 3'b010, 2'd1, 1'b1, 1'b0, 0);
    push(0, b + 4, 3'b010, 2'd1, 1'b1, 1'b0, 0);
    push(0, b + 5, 3'b100, 2'd2, 1'b1, 1'b0, 0);
    push(0, b + 6, 3'b000, 2'd0, 1'b1, 1'b0, 0);
    push(0, b + 7, 3'b000, 2'd0, 1'b0, 1'b1, 1);
    push(0, b + 8, 3'b000, 2'd0, 1'b0, 1'b0, 1);
    tick(1);
    start_a = 1'b0;
    tick(1);
    stall_a = 1'b1;
    tick(2);
    stall_a = 1'b0;
    tick(5);

    // Stall over the last GAP cycle: done still a single pulse
    b = cyc;
    start_a = 1'b1;
    push(0, b + 1, 3'b001, 2'd0, 1'b1, 1'b0, 1);
    push(0, b + 2, 3'b010, 2'd1, 1'b1, 1'b0, 1);
    push(0, b + 3, 3'b100, 2'd2, 1'b1, 1'b0, 1);
    push(0, b + 4, 3'b000, 2'd0, 1'b1, 1'b0, 1);
    push(0, b + 5, 3'b000, 2'd0, 1'b1, 1'b0, 1);
    push(0, b + 6, 3'b000, 2'd0, 1'b1, 1'b0, 1);
    push(0, b + 7, 3'b000, 2'd0, 1'b0, 1'b1, 2);
    push(0, b + 8, 3'b000, 2'd0, 1'b0, 1'b0, 2);
    tick(1);
    start_a = 1'b0;
    tick(3);
    stall_a = 1'b1;
    tick(2);
    stall_a = 1'b0;
    tick(4);
`endif

    tick(2);
    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
